mrfm_decim_avg: RTL and testbench

//  Decimating boxcar averager placed directly after the ADC summing switch in mrfm.v.

---
 rtl/mrfm_decim_avg_pkg.sv | 25 ++
 rtl/mrfm_decim_avg_setting.sv | 44 ++++
 rtl/mrfm_decim_avg.sv | 124 ++++++++++++
 tb/tb_mrfm_decim_avg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mrfm_decim_avg_pkg.sv
// mrfm_decim_avg_pkg
//   Shared constants for the MRFM decimating boxcar averager: sample width,
//   default maximum decimation, settings-bus address of the shift register and
//   the saturation limits. The helper clamp_shift limits a programmed shift to
//   the largest decimation the accumulator was sized for.
package mrfm_decim_avg_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int SAMPLE_W             = 16;
  localparam int MRFM_DECIM_MAX_SHIFT = 8;

  // The decimation shift takes the next free settings address after the K1 scale.
  localparam logic [6:0] FR_MRFM_SCALE_K1    = 7'd70;
  localparam logic [6:0] FR_MRFM_DECIM_SHIFT = FR_MRFM_SCALE_K1 + 7'd1;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  function automatic logic [3:0] clamp_shift(input logic [3:0] shift_reg, input int max_shift);
    if (int'(shift_reg) > max_shift) return 4'(max_shift);
    return shift_reg;
  endfunction

endpackage

// File: rtl/mrfm_decim_avg_setting.sv
// mrfm_decim_avg_setting
//   Settings-bus register in the style of setting_reg: captures the low WIDTH
//   bits of serial_data when serial_strobe hits ADDR, and pulses changed for
//   one cycle alongside the new value.
// Ports
//   clock, reset          master clock, asynchronous active-high reset
//   serial_addr/data      settings bus address and data
//   serial_strobe         settings bus write strobe
//   value                 current register contents (RESET_VAL after reset)
//   changed               one-cycle pulse, high the cycle the new value appears
module mrfm_decim_avg_setting
  import mrfm_decim_avg_pkg::*;
#(
  parameter logic [6:0] ADDR      = FR_MRFM_DECIM_SHIFT,
  parameter int         WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       serial_addr,
  input  logic [31:0]      serial_data,
  input  logic             serial_strobe,
  output logic [WIDTH-1:0] value,
  output logic             changed
);

  // Only the low bits are meaningful for this register.
  logic unused_data_bits;
  assign unused_data_bits = ^serial_data[31:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value   <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (serial_strobe && (serial_addr == ADDR)) begin
        value   <= serial_data[WIDTH-1:0];
        changed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mrfm_decim_avg.sv
// mrfm_decim_avg
//   Decimating boxcar averager after the ADC summing switch. Accumulates
//   2^shift_eff signed samples and emits one 16-bit average per block with a
//   one-cycle strobe. shift_eff is the programmed shift clamped to MAX_SHIFT;
//   shift 0 is a one-cycle-delayed pass-through.
// Configuration macro
//   MRFM_DECIM_ROUND_EN  defined: round half up and saturate to 16 bits;
//                        undefined: arithmetic-shift truncation toward -inf.
// Ports
//   clock, reset          master clock, asynchronous active-high reset
//   serial_addr/data/strobe  settings bus (shift at FR_MRFM_DECIM_SHIFT)
//   in_strobe, in         valid flag and signed sample
//   out_strobe, out       one-cycle new-average pulse and held average
//   busy                  a block is partially accumulated
module mrfm_decim_avg
  import mrfm_decim_avg_pkg::*;
#(
  parameter int MAX_SHIFT = MRFM_DECIM_MAX_SHIFT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        in_strobe,
  input  logic [15:0] in,
  output logic        out_strobe,
  output logic [15:0] out,
  output logic        busy
);

  localparam int ACC_W = SAMPLE_W + MAX_SHIFT;
  localparam int CNT_W = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;

  logic [3:0]              shift_reg;
  logic                    shift_changed;
  logic [3:0]              shift_eff;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        last_count;
  logic                    last_sample;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   shifted;
  logic [15:0]             avg;

  mrfm_decim_avg_setting #(
    .ADDR      (FR_MRFM_DECIM_SHIFT),
    .WIDTH     (4),
    .RESET_VAL (4'd0)
  ) u_shift_reg (
    .clock         (clock),
    .reset         (reset),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .value         (shift_reg),
    .changed       (shift_changed)
  );

  assign shift_eff = clamp_shift(shift_reg, MAX_SHIFT);

  assign acc_next = acc + {{MAX_SHIFT{in[15]}}, in};

  // N-1 as a mask of shift_eff ones; all-zero when shift_eff is 0 so every sample ends a block.
  assign last_count  = {CNT_W{1'b1}} >> (CNT_W - int'(shift_eff));
  assign last_sample = (count == last_count);

`ifdef MRFM_DECIM_ROUND_EN
  assign rnd = (shift_eff == 4'd0) ? '0 : ((ACC_W+1)'(1) << (shift_eff - 4'd1));
`else
  assign rnd = '0;
`endif

  // One guard bit above the accumulator so adding the rounding constant cannot wrap.
  assign rounded = {acc_next[ACC_W-1], acc_next} + rnd;
  assign shifted = rounded >>> shift_eff;

`ifdef MRFM_DECIM_ROUND_EN
  localparam logic signed [ACC_W:0] MAX_S = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] MIN_S = -(ACC_W+1)'(32768);

  always_comb begin
    avg = shifted[15:0];
    if (shifted > MAX_S)      avg = SAT_POS;
    else if (shifted < MIN_S) avg = SAT_NEG;
  end
`else
  // Without rounding the shifted block mean always fits in 16 bits.
  logic unused_shift_msbs;
  assign unused_shift_msbs = ^shifted[ACC_W:16];
  assign avg = shifted[15:0];
`endif

  // A shift change restarts the block and wins over a coincident sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      out        <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (shift_changed) begin
        acc   <= '0;
        count <= '0;
      end else if (in_strobe) begin
        if (last_sample) begin
          out        <= avg;
          out_strobe <= 1'b1;
          acc        <= '0;
          count      <= '0;
        end else begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: tb/tb_mrfm_decim_avg.sv
// tb_mrfm_decim_avg
//   Self-checking bench for mrfm_decim_avg: a table of short blocks with
//   hand-computed averages for both rounding builds, then multi-cycle corner
//   cases (reset mid-block, full-scale blocks, pass-through stream, shift
//   change mid-block, clamped shift). Expected averages are queued with their
//   due cycle when the final sample is driven and compared when out_strobe fires.
module tb_mrfm_decim_avg;
  import mrfm_decim_avg_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        in_strobe;
  logic [15:0] in_data;
  logic        out_strobe;
  logic [15:0] out;
  logic        busy;

  mrfm_decim_avg dut (
    .clock         (clock),
    .reset         (reset),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .in_strobe     (in_strobe),
    .in            (in_data),
    .out_strobe    (out_strobe),
    .out           (out),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  typedef struct {
    int          shift;
    logic [15:0] samp[4];
    logic [15:0] exp_trunc;
    logic [15:0] exp_round;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Every out_strobe must match the oldest queued expectation, value and cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (out_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got out=%0h required no strobe", out);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_value", out, e.val);
        checkOutput("out_latency", cyc, e.due);
      end
    end
  end

  task automatic driveSample(input logic [15:0] v, input bit push, input logic [15:0] e);
    exp_t x;
    @(negedge clock);
    in_strobe = 1'b1;
    in_data   = v;
    if (push) begin
      x.val = e;
      x.due = cyc + 1;
      exp_q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_strobe = 1'b0;
    end
  endtask

  // Waits for the write to land and for the restart pulse to pass.
  task automatic writeShift(input int s);
    @(negedge clock);
    in_strobe     = 1'b0;
    serial_addr   = FR_MRFM_DECIM_SHIFT;
    serial_data   = 32'(s);
    serial_strobe = 1'b1;
    @(negedge clock);
    serial_strobe = 1'b0;
    @(negedge clock);
  endtask

  task automatic waitDrain(input string name);
    idle(1);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d pending outputs required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic applyStimulus();
    int          cur_shift;
    int          n;
    logic [15:0] e;
    logic [15:0] r;

    vecs[0] = '{2, '{16'd100, 16'd200, 16'd300, 16'd401}, 16'd250, 16'd250};
    vecs[1] = '{2, '{16'hFFFD, 16'hFFFE, 16'hFFFE, 16'hFFFE}, 16'hFFFD, 16'hFFFE};
    vecs[2] = '{1, '{16'd5, 16'd6, 16'd0, 16'd0}, 16'd5, 16'd6};
    vecs[3] = '{1, '{16'hFFFB, 16'hFFFA, 16'd0, 16'd0}, 16'hFFFA, 16'hFFFB};
    vecs[4] = '{0, '{16'd1234, 16'd0, 16'd0, 16'd0}, 16'd1234, 16'd1234};
    vecs[5] = '{0, '{16'h8000, 16'd0, 16'd0, 16'd0}, 16'h8000, 16'h8000};
    vecs[6] = '{2, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 16'h7FFF};
    vecs[7] = '{1, '{16'd7, 16'd8, 16'd0, 16'd0}, 16'd7, 16'd8};
    vecs[8] = '{2, '{16'd1, 16'd1, 16'd1, 16'd0}, 16'd0, 16'd1};

    serial_addr   = '0;
    serial_data   = '0;
    serial_strobe = 1'b0;
    in_strobe     = 1'b0;
    in_data       = '0;
    reset         = 1'b1;
    #1;
    checkOutput("reset_out", out, 16'd0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_strobe", out_strobe, 0);
    idle(2);
    reset = 1'b0;
    cur_shift = 0;

    // Table of short blocks with random gaps between samples.
    e = '0;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].shift != cur_shift) writeShift(vecs[i].shift);
      cur_shift = vecs[i].shift;
      n = 1 << cur_shift;
`ifdef MRFM_DECIM_ROUND_EN
      e = vecs[i].exp_round;
`else
      e = vecs[i].exp_trunc;
`endif
      for (int j = 0; j < n; j++) begin
        driveSample(vecs[i].samp[j], j == n - 1, e);
        idle($urandom_range(0, 2));
      end
      waitDrain("table_drain");
    end
    idle(4);
    checkOutput("out_hold", out, e);

    // Reset in the middle of a block clears everything without a clock edge.
    writeShift(2);
    for (int j = 0; j < 4; j++) driveSample(16'd40, j == 3, 16'd40);
    waitDrain("pre_reset_drain");
    driveSample(16'd100, 1'b0, 16'd0);
    driveSample(16'd200, 1'b0, 16'd0);
    idle(1);
    checkOutput("busy_mid_block", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out", out, 16'd0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_strobe", out_strobe, 0);
    idle(2);
    reset = 1'b0;

    // Reset returns the shift to pass-through: a full-rate random stream echoes.
    for (int j = 0; j < 40; j++) begin
      r = 16'($urandom);
      driveSample(r, 1'b1, r);
    end
    waitDrain("passthru_drain");

    // Full-scale blocks at the largest decimation.
    writeShift(8);
    for (int j = 0; j < 256; j++) driveSample(16'h7FFF, j == 255, 16'h7FFF);
    waitDrain("max_pos_drain");
    for (int j = 0; j < 256; j++) driveSample(16'h8000, j == 255, 16'h8000);
    waitDrain("max_neg_drain");

    // Shift change mid-block: partial block and coincident samples are dropped.
    writeShift(3);
    for (int j = 0; j < 5; j++) driveSample(16'd50, 1'b0, 16'd0);
    @(negedge clock);
    serial_addr   = FR_MRFM_DECIM_SHIFT;
    serial_data   = 32'd1;
    serial_strobe = 1'b1;
    in_strobe     = 1'b1;
    in_data       = 16'd77;
    @(negedge clock);
    serial_strobe = 1'b0;
    in_data       = 16'd999;
    idle(1);
    checkOutput("restart_busy", busy, 0);
    driveSample(16'd10, 1'b0, 16'd0);
    idle(1);
    driveSample(16'd20, 1'b1, 16'd15);
    waitDrain("restart_drain");

    // A shift beyond the maximum behaves as the maximum.
    writeShift(15);
    for (int j = 0; j < 255; j++) driveSample(16'd3, 1'b0, 16'd0);
    idle(2);
    checkOutput("clamp_busy", busy, 1);
    driveSample(16'd3, 1'b1, 16'd3);
    waitDrain("clamp_drain");
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish required finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
